pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges the load-use/branch stall request from the hazard unit, ID-stage branch/jump redirects, EX-stage exceptions, and instruction/data memory wait handshakes into per-stage write-enable and flush controls. A wait-state FSM with a timeout converts a hung memory into a bus-error exception. Saturating performance counters record stall and flush cycles.

---
 rtl/pipeline_ctrl_pkg.sv | 25 ++
 rtl/pipeline_ctrl_if.sv | 49 ++++
 rtl/pipeline_ctrl_sat_counter.sv | 32 +++
 rtl/pipeline_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and encodings for the pipeline stall/flush
//               sequencer: wait-state FSM states and exception cause codes.
// Contents    : state_t    - RUN / IWAIT / DWAIT / BERR
//               CAUSE_*    - Exc_Cause encodings
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      IWAIT = 2'd1,
      DWAIT = 2'd2,
      BERR  = 2'd3
   } state_t;

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_EX   = 2'b01;
   localparam logic [1:0] CAUSE_IBUS = 2'b10;
   localparam logic [1:0] CAUSE_DBUS = 2'b11;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Bundle of hazard/memory event inputs and per-stage control
//               outputs of the pipeline sequencer.
// Modports    : master - pipeline side: drives events, receives controls
//               slave  - sequencer side: receives events, drives controls
// Parameters  : CNT_W - performance counter width
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             Stall;
   logic             ID_Redirect;
   logic             EX_Exception;
   logic             IF_MemWait;
   logic             MEM_MemWait;
   logic             PC_Write;
   logic             PC_ExcSel;
   logic             EPC_Write;
   logic [1:0]       Exc_Cause;
   logic             IF_ID_Write;
   logic             IF_ID_Flush;
   logic             ID_EX_Write;
   logic             ID_EX_Flush;
   logic             EX_MEM_Write;
   logic             EX_MEM_Flush;
   logic             MEM_WB_Flush;
   logic [CNT_W-1:0] Stall_Cnt;
   logic [CNT_W-1:0] Flush_Cnt;

   modport master (
      output Stall, ID_Redirect, EX_Exception, IF_MemWait, MEM_MemWait,
      input  PC_Write, PC_ExcSel, EPC_Write, Exc_Cause,
      input  IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
      input  EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush,
      input  Stall_Cnt, Flush_Cnt
   );

   modport slave (
      input  Stall, ID_Redirect, EX_Exception, IF_MemWait, MEM_MemWait,
      output PC_Write, PC_ExcSel, EPC_Write, Exc_Cause,
      output IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
      output EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush,
      output Stall_Cnt, Flush_Cnt
   );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Ports       : clk     - clock, rising edge
//               reset   - asynchronous active-low reset (clears to 0)
//               i_inc   - count enable for this cycle
//               o_value - current count
// Parameters  : WIDTH - counter width
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             i_inc,
   output logic      [WIDTH-1:0] o_value
);
   logic [WIDTH-1:0] r_value;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_value <= '0;
      end else if (i_inc && (r_value != '1)) begin
         r_value <= r_value + WIDTH'(1);
      end
   end

   assign o_value = r_value;
endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/flush sequencer for the 5-stage pipeline. Merges hazard
//               stalls, ID redirects, EX exceptions and memory wait states
//               into per-stage write-enable/flush controls. A wait-state FSM
//               turns a memory that waits too long into a bus-error exception.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous active-low reset
//               pipe  - pipeline_ctrl_if.slave (events in, controls and
//                       performance counters out)
// Parameters  : MAX_WAIT - wait cycles tolerated before a bus error (>=2)
//               WAIT_W   - wait counter width, 2**WAIT_W > MAX_WAIT
//               CNT_W    - performance counter width
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
   import pipe_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int WAIT_W   = 5,
   parameter int CNT_W    = 32
) (
   input wire logic      clk,
   input wire logic      reset,
   pipeline_ctrl_if.slave pipe
);
   localparam logic [WAIT_W-1:0] C_LAST = WAIT_W'(MAX_WAIT - 1);

   state_t            r_state, w_state_nxt;
   logic [WAIT_W-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]        r_berr_cause, w_berr_cause_nxt;

   logic       w_pc_write, w_pc_excsel, w_epc_write;
   logic [1:0] w_cause;
   logic       w_ifid_w, w_ifid_f, w_idex_w, w_idex_f, w_exmem_w, w_exmem_f;
   logic       w_memwb_f, w_redirect_win;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= RUN;
         r_cnt        <= '0;
         r_berr_cause <= CAUSE_NONE;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_berr_cause <= w_berr_cause_nxt;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_berr_cause_nxt = r_berr_cause;
      case (r_state)
         RUN: begin
            if (pipe.EX_Exception) begin
               w_cnt_nxt = '0;
            end else if (pipe.MEM_MemWait) begin
               w_state_nxt = DWAIT;
               w_cnt_nxt   = WAIT_W'(1);
            end else if (pipe.IF_MemWait && !pipe.ID_Redirect) begin
               w_state_nxt = IWAIT;
               w_cnt_nxt   = WAIT_W'(1);
            end
         end
         IWAIT: begin
            if (pipe.EX_Exception || (!pipe.MEM_MemWait && !pipe.IF_MemWait)) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end else if (pipe.MEM_MemWait) begin
               // data-side wait takes over; its timeout starts afresh
               w_state_nxt = DWAIT;
               w_cnt_nxt   = WAIT_W'(1);
            end else if (r_cnt == C_LAST) begin
               w_state_nxt      = BERR;
               w_cnt_nxt        = '0;
               w_berr_cause_nxt = CAUSE_IBUS;
            end else begin
               w_cnt_nxt = r_cnt + WAIT_W'(1);
            end
         end
         DWAIT: begin
            if (pipe.EX_Exception || !pipe.MEM_MemWait) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end else if (r_cnt == C_LAST) begin
               w_state_nxt      = BERR;
               w_cnt_nxt        = '0;
               w_berr_cause_nxt = CAUSE_DBUS;
            end else begin
               w_cnt_nxt = r_cnt + WAIT_W'(1);
            end
         end
         default: begin
            // BERR lasts exactly one cycle regardless of inputs
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // ---------------- output decode (priority order) ----------------
   always_comb begin
      w_pc_write     = 1'b1;
      w_pc_excsel    = 1'b0;
      w_epc_write    = 1'b0;
      w_cause        = CAUSE_NONE;
      w_ifid_w       = 1'b1;
      w_ifid_f       = 1'b0;
      w_idex_w       = 1'b1;
      w_idex_f       = 1'b0;
      w_exmem_w      = 1'b1;
      w_exmem_f      = 1'b0;
      w_memwb_f      = 1'b0;
      w_redirect_win = 1'b0;
      if (!reset) begin
         w_pc_write = 1'b0;
         w_ifid_w   = 1'b0;
         w_idex_w   = 1'b0;
         w_exmem_w  = 1'b0;
      end else if (r_state == BERR) begin
         w_pc_excsel = 1'b1;
         w_epc_write = 1'b1;
         w_cause     = r_berr_cause;
         w_ifid_f    = 1'b1;
         w_idex_f    = 1'b1;
         w_exmem_f   = 1'b1;
         w_memwb_f   = 1'b1;
      end else if (pipe.EX_Exception) begin
         w_pc_excsel = 1'b1;
         w_epc_write = 1'b1;
         w_cause     = CAUSE_EX;
         w_ifid_f    = 1'b1;
         w_idex_f    = 1'b1;
         w_exmem_f   = 1'b1;
      end else if (pipe.MEM_MemWait) begin
         // freeze everything upstream of MEM, feed a bubble into WB
         w_pc_write = 1'b0;
         w_ifid_w   = 1'b0;
         w_idex_w   = 1'b0;
         w_exmem_w  = 1'b0;
         w_memwb_f  = 1'b1;
      end else if (pipe.Stall) begin
         w_pc_write = 1'b0;
         w_ifid_w   = 1'b0;
         w_idex_f   = 1'b1;
      end else if (pipe.ID_Redirect) begin
         w_ifid_f       = 1'b1;
         w_redirect_win = 1'b1;
      end else if (pipe.IF_MemWait) begin
         w_pc_write = 1'b0;
         w_ifid_f   = 1'b1;
      end
   end

   assign pipe.PC_Write     = w_pc_write;
   assign pipe.PC_ExcSel    = w_pc_excsel;
   assign pipe.EPC_Write    = w_epc_write;
   assign pipe.Exc_Cause    = w_cause;
   assign pipe.IF_ID_Write  = w_ifid_w;
   assign pipe.IF_ID_Flush  = w_ifid_f;
   assign pipe.ID_EX_Write  = w_idex_w;
   assign pipe.ID_EX_Flush  = w_idex_f;
   assign pipe.EX_MEM_Write = w_exmem_w;
   assign pipe.EX_MEM_Flush = w_exmem_f;
   assign pipe.MEM_WB_Flush = w_memwb_f;

   // ---------------- performance counters ----------------
   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (!w_pc_write),
      .o_value (pipe.Stall_Cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_redirect_win),
      .o_value (pipe.Flush_Cnt)
   );
endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. Directed scenarios
//               followed by randomized traffic, compared against a
//               run-length reference model of the wait/timeout behaviour.
//               Counters are built narrow so saturation is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;
   localparam int MAX_WAIT = 16;
   localparam int WAIT_W   = 5;
   localparam int CNT_W    = 4;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic clk;
   logic reset;

   pipeline_ctrl_if #(.CNT_W(CNT_W)) pipe ();

   pipeline_ctrl #(
      .MAX_WAIT (MAX_WAIT),
      .WAIT_W   (WAIT_W),
      .CNT_W    (CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .pipe  (pipe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   // reference model: which memory is being waited on and for how long
   int         m_src;      // 0 none, 1 instruction, 2 data
   int         m_len;      // consecutive wait cycles seen so far
   bit         m_berr;     // bus-error cycle due now
   logic [1:0] m_berr_cause;
   int         m_stall;
   int         m_flush;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] ctl_word();
      return {pipe.PC_Write, pipe.PC_ExcSel, pipe.EPC_Write, pipe.Exc_Cause,
              pipe.IF_ID_Write, pipe.IF_ID_Flush, pipe.ID_EX_Write, pipe.ID_EX_Flush,
              pipe.EX_MEM_Write, pipe.EX_MEM_Flush, pipe.MEM_WB_Flush};
   endfunction

   task automatic model_clear();
      m_src = 0; m_len = 0; m_berr = 0; m_berr_cause = 2'b00;
      m_stall = 0; m_flush = 0;
   endtask

   // called at posedge+1: assert reset, check reset outputs, release next cycle
   task automatic pulse_reset();
      reset = 1'b0;
      pipe.Stall = 0; pipe.ID_Redirect = 0; pipe.EX_Exception = 0;
      pipe.IF_MemWait = 0; pipe.MEM_MemWait = 0;
      #2;
      chk("rst_ctl", 32'(ctl_word()), 32'h0);
      chk("rst_scnt", 32'(pipe.Stall_Cnt), 32'h0);
      chk("rst_fcnt", 32'(pipe.Flush_Cnt), 32'h0);
      model_clear();
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   // one clock cycle: apply inputs, check at negedge, advance model at posedge
   task automatic step(input bit st, input bit idr, input bit ex, input bit ifw, input bit mw);
      bit pw, xs, epc, fw, ff, dw, df, ew, ef, wf, red;
      logic [1:0] cause;
      pipe.Stall = st; pipe.ID_Redirect = idr; pipe.EX_Exception = ex;
      pipe.IF_MemWait = ifw; pipe.MEM_MemWait = mw;
      @(negedge clk);
      pw = 1; xs = 0; epc = 0; cause = 2'b00; fw = 1; ff = 0; dw = 1; df = 0;
      ew = 1; ef = 0; wf = 0; red = 0;
      if (m_berr) begin
         xs = 1; epc = 1; cause = m_berr_cause; ff = 1; df = 1; ef = 1; wf = 1;
      end else if (ex) begin
         xs = 1; epc = 1; cause = 2'b01; ff = 1; df = 1; ef = 1;
      end else if (mw) begin
         pw = 0; fw = 0; dw = 0; ew = 0; wf = 1;
      end else if (st) begin
         pw = 0; fw = 0; df = 1;
      end else if (idr) begin
         ff = 1; red = 1;
      end else if (ifw) begin
         pw = 0; ff = 1;
      end
      chk("ctl", 32'(ctl_word()), 32'({pw, xs, epc, cause, fw, ff, dw, df, ew, ef, wf}));
      chk("scnt", 32'(pipe.Stall_Cnt), 32'(m_stall));
      chk("fcnt", 32'(pipe.Flush_Cnt), 32'(m_flush));
      // counters
      if (!pw && m_stall < CNT_MAX) m_stall++;
      if (red && m_flush < CNT_MAX) m_flush++;
      // wait tracking
      if (m_berr) begin
         m_berr = 0; m_src = 0; m_len = 0;
      end else if (ex) begin
         m_src = 0; m_len = 0;
      end else if (mw) begin
         if (m_src == 2) m_len++;
         else begin m_src = 2; m_len = 1; end
      end else if (m_src == 2) begin
         m_src = 0; m_len = 0;
      end else if (m_src == 1) begin
         if (ifw) m_len++;
         else begin m_src = 0; m_len = 0; end
      end else if (ifw && !idr) begin
         m_src = 1; m_len = 1;
      end
      if (m_len == MAX_WAIT) begin
         m_berr = 1;
         m_berr_cause = (m_src == 2) ? 2'b11 : 2'b10;
         m_src = 0; m_len = 0;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      model_clear();
      reset = 1'b0;
      pipe.Stall = 0; pipe.ID_Redirect = 0; pipe.EX_Exception = 0;
      pipe.IF_MemWait = 0; pipe.MEM_MemWait = 0;
      @(posedge clk); #1;
      pulse_reset();

      // reset release with Stall held, then count check
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      // stall beats redirect, then redirect alone
      step(1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      // short data wait
      repeat (3) step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      // redirect overrides instruction wait
      step(0, 1, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      // data wait dropping on the last tolerated cycle: no error
      repeat (MAX_WAIT - 1) step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      // data wait held: bus error, inputs ignored during the error cycle
      pulse_reset();
      repeat (MAX_WAIT) step(0, 0, 0, 0, 1);
      step(1, 1, 1, 1, 1);
      step(0, 0, 0, 0, 0);
      // instruction wait held alone: bus error cause 10
      repeat (MAX_WAIT) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      // instruction wait promoted to data wait: cause 11
      repeat (4) step(0, 0, 0, 1, 0);
      repeat (MAX_WAIT) step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0);
      // exception against freeze and stall
      step(1, 0, 1, 0, 1);
      step(0, 0, 0, 0, 0);
      // reset in the middle of a data wait
      repeat (5) step(0, 0, 0, 0, 1);
      pulse_reset();
      step(0, 0, 0, 0, 0);
      // reset while a bus error is pending
      repeat (MAX_WAIT) step(0, 0, 0, 0, 1);
      pulse_reset();
      step(0, 0, 0, 0, 0);

      // randomized traffic in blocks; some blocks hold a wait line high
      for (int blk = 0; blk < 12; blk++) begin
         int hold;
         hold = $urandom_range(0, 3);
         for (int i = 0; i < 30; i++) begin
            bit st, idr, ex, ifw, mw;
            st  = ($urandom_range(0, 99) < 20);
            idr = ($urandom_range(0, 99) < 25);
            ex  = ($urandom_range(0, 99) < 4);
            ifw = (hold == 1) || ($urandom_range(0, 99) < 25);
            mw  = (hold == 2) || ($urandom_range(0, 99) < 15);
            step(st, idr, ex, ifw, mw);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
